locked_tap_counter: RTL and testbench

LOCKED_TAP_COUNTER -- requirements
Module: locked_tap_counter

---
 rtl/locked_tap_counter.sv | 132 +++++++++++++
 tb/tb_locked_tap_counter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_tap_counter.sv
// Free-running counter gated by a qualified PLL lock, with per-channel LED taps
// that either follow a selected counter bit (level) or pulse on its rising edge (strobe).
module locked_tap_counter #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int QUAL_CYCLES = 1024
) (
    input  logic                                 CLK,
    input  logic                                 BTN_USR,
    input  logic                                 PLL_LOCK,
    input  logic                                 CLR,
    input  logic [CHANNELS*$clog2(WIDTH)-1:0]    TAP_SEL,
    input  logic [CHANNELS-1:0]                  MODE,
    output logic [CHANNELS-1:0]                  LED,
    output logic                                 RUNNING,
    output logic [WIDTH-1:0]                     COUNT
);

    localparam int TAPW = $clog2(WIDTH);
    localparam int QW   = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
    localparam logic [QW-1:0]   QUAL_LAST = QW'(QUAL_CYCLES - 1);
    // One extra bit so tap indices past WIDTH (non-power-of-two widths) are detectable
    localparam logic [TAPW:0]   WIDTH_LIM = (TAPW + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        RUN
    } state_t;

    state_t            state_reg, state_next;
    logic              sync1_reg, lock_s_reg;
    logic [QW-1:0]     qual_cnt_reg, qual_cnt_next;
    logic [WIDTH-1:0]  count_reg, count_next;
    logic              running_reg;
    logic              run_next;

    always_ff @(posedge CLK or negedge BTN_USR) begin
        if (!BTN_USR) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= PLL_LOCK;
            lock_s_reg <= sync1_reg;
        end
    end

    always_ff @(posedge CLK or negedge BTN_USR) begin
        if (!BTN_USR) begin
            state_reg    <= IDLE;
            qual_cnt_reg <= '0;
            count_reg    <= '0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            qual_cnt_reg <= qual_cnt_next;
            count_reg    <= count_next;
            running_reg  <= run_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        qual_cnt_next = qual_cnt_reg;
        count_next    = '0;
        case (state_reg)
            IDLE: begin
                if (lock_s_reg) begin
                    state_next    = QUAL;
                    qual_cnt_next = '0;
                end
            end
            QUAL: begin
                if (!lock_s_reg) begin
                    state_next = IDLE;
                end else if (qual_cnt_reg == QUAL_LAST) begin
                    state_next = RUN;
                end else begin
                    qual_cnt_next = qual_cnt_reg + QW'(1);
                end
            end
            RUN: begin
                if (!lock_s_reg) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Clear overrides increment but leaves the FSM alone
        if (CLR) begin
            count_next = '0;
        end
    end

    assign run_next = (state_next == RUN);
    assign RUNNING  = running_reg;
    assign COUNT    = count_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [TAPW-1:0] sel;
        logic [TAPW-1:0] sel_reg;
        logic            tap;
        logic            prev_reg;
        logic            led_reg;

        assign sel = TAP_SEL[gi*TAPW +: TAPW];
        assign tap = ({1'b0, sel} < WIDTH_LIM) ? count_reg[sel] : 1'b0;

        // A tap move reloads the previous sample silently, so no false strobe
        always_ff @(posedge CLK or negedge BTN_USR) begin
            if (!BTN_USR) begin
                sel_reg  <= '0;
                prev_reg <= 1'b0;
                led_reg  <= 1'b0;
            end else begin
                sel_reg <= sel;
                if (run_next) begin
                    prev_reg <= tap;
                    led_reg  <= MODE[gi] ? (tap & ~prev_reg & (sel == sel_reg)) : tap;
                end else begin
                    prev_reg <= 1'b0;
                    led_reg  <= 1'b0;
                end
            end
        end

        assign LED[gi] = led_reg;
    end

endmodule

// File: tb/tb_locked_tap_counter.sv
// Bench for locked_tap_counter: directed scenarios plus randomized traffic
// checked against a lock-streak based reference model.
module tb_locked_tap_counter;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int Q  = 4;
    localparam int TW = 3;

    logic              CLK = 1'b0;
    logic              BTN_USR = 1'b1;
    logic              PLL_LOCK = 1'b0;
    logic              CLR = 1'b0;
    logic [CH*TW-1:0]  TAP_SEL = '0;
    logic [CH-1:0]     MODE = '0;
    logic [CH-1:0]     LED;
    logic              RUNNING;
    logic [W-1:0]      COUNT;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic              m_h1, m_h2;
    int                m_streak;
    logic              m_run;
    logic [W-1:0]      m_count;
    logic [CH-1:0]     m_led, m_prev;
    logic [TW-1:0]     m_sel_last [CH];

    locked_tap_counter #(.WIDTH(W), .CHANNELS(CH), .QUAL_CYCLES(Q)) dut (
        .CLK      (CLK),
        .BTN_USR  (BTN_USR),
        .PLL_LOCK (PLL_LOCK),
        .CLR      (CLR),
        .TAP_SEL  (TAP_SEL),
        .MODE     (MODE),
        .LED      (LED),
        .RUNNING  (RUNNING),
        .COUNT    (COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_h1 = 1'b0;
        m_h2 = 1'b0;
        m_streak = 0;
        m_run = 1'b0;
        m_count = '0;
        m_led = '0;
        m_prev = '0;
        for (int c = 0; c < CH; c++) m_sel_last[c] = '0;
    endtask

    // One clock edge: model sees the same pre-edge inputs as the DUT.
    // Running means lock_s has been high on Q+1 consecutive edges.
    task automatic tick();
        logic              pll, clr, lock_pre, run_pre, tap;
        logic [CH*TW-1:0]  sel;
        logic [CH-1:0]     mode;
        logic [W-1:0]      cnt_pre;
        logic [TW-1:0]     s;
        pll = PLL_LOCK;
        clr = CLR;
        sel = TAP_SEL;
        mode = MODE;
        @(posedge CLK);
        lock_pre = m_h2;
        m_h2 = m_h1;
        m_h1 = pll;
        run_pre = m_run;
        cnt_pre = m_count;
        if (!lock_pre) m_streak = 0;
        else if (m_streak <= Q) m_streak++;
        m_run = (m_streak > Q);
        if (clr) m_count = '0;
        else if (run_pre && lock_pre) m_count = cnt_pre + 8'd1;
        else m_count = '0;
        for (int c = 0; c < CH; c++) begin
            s = sel[c*TW +: TW];
            tap = (int'(s) < W) ? cnt_pre[s] : 1'b0;
            if (m_run) begin
                m_led[c] = mode[c] ? (tap && !m_prev[c] && (s == m_sel_last[c])) : tap;
                m_prev[c] = tap;
            end else begin
                m_led[c] = 1'b0;
                m_prev[c] = 1'b0;
            end
            m_sel_last[c] = s;
        end
        #1;
    endtask

    task automatic test_reset();
        #1 BTN_USR = 1'b0;
        #1;
        if ({RUNNING, COUNT, LED} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got run=%b count=%0d led=%b, required all 0", RUNNING, COUNT, LED);
        end
        vectors++;
        $display("txn reset_async run=%b count=%0d led=%b", RUNNING, COUNT, LED);
        repeat (2) @(posedge CLK);
        #1;
        if ({RUNNING, COUNT, LED} !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got run=%b count=%0d led=%b, required all 0", RUNNING, COUNT, LED);
        end
        vectors++;
        $display("txn reset_held run=%b count=%0d led=%b", RUNNING, COUNT, LED);
        model_reset();
        TAP_SEL = '0;
        MODE = '0;
        PLL_LOCK = 1'b1;
        BTN_USR = 1'b1;
    endtask

    task automatic test_lock_latency();
        for (int e = 1; e <= 10; e++) begin
            tick();
            if ({RUNNING, COUNT} !== {(e >= 7) ? 1'b1 : 1'b0, (e >= 7) ? W'(e - 7) : W'(0)}) begin
                miscompares++;
                $display("FAIL lock_latency e=%0d: got run=%b count=%0d, required run=%b count=%0d",
                         e, RUNNING, COUNT, (e >= 7), (e >= 7) ? e - 7 : 0);
            end
            vectors++;
            $display("txn lock_latency e=%0d run=%b count=%0d", e, RUNNING, COUNT);
        end
    endtask

    task automatic test_qual_dropout();
        PLL_LOCK = 1'b0;
        repeat (4) tick();
        PLL_LOCK = 1'b1;
        repeat (4) tick();
        PLL_LOCK = 1'b0;
        repeat (3) begin
            tick();
            if ({RUNNING, COUNT} !== {1'b0, W'(0)}) begin
                miscompares++;
                $display("FAIL qual_dropout: got run=%b count=%0d, required run=0 count=0", RUNNING, COUNT);
            end
            vectors++;
            $display("txn qual_dropout run=%b count=%0d", RUNNING, COUNT);
        end
        PLL_LOCK = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (RUNNING !== ((e >= 7) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL requal e=%0d: got run=%b, required %b", e, RUNNING, (e >= 7));
            end
            vectors++;
            if ({RUNNING, COUNT, LED} !== {m_run, m_count, m_led}) begin
                miscompares++;
                $display("FAIL requal_model e=%0d: got %b/%0d/%b, required %b/%0d/%b",
                         e, RUNNING, COUNT, LED, m_run, m_count, m_led);
            end
            vectors++;
            $display("txn requal e=%0d run=%b count=%0d", e, RUNNING, COUNT);
        end
    endtask

    task automatic test_wrap_level();
        int guard = 0;
        TAP_SEL[2:0] = 3'd7;
        MODE[0] = 1'b0;
        while (COUNT !== 8'd255 && guard < 300) begin
            tick();
            guard++;
            if ({RUNNING, COUNT, LED} !== {m_run, m_count, m_led}) begin
                miscompares++;
                $display("FAIL wrap_model: got %b/%0d/%b, required %b/%0d/%b",
                         RUNNING, COUNT, LED, m_run, m_count, m_led);
            end
            vectors++;
        end
        if (COUNT !== 8'd255) begin
            miscompares++;
            $display("FAIL wrap_reach: got count=%0d after %0d cycles, required 255", COUNT, guard);
        end
        vectors++;
        tick();
        if ({COUNT, LED[0]} !== {8'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_zero: got count=%0d led0=%b, required count=0 led0=1", COUNT, LED[0]);
        end
        vectors++;
        $display("txn wrap_zero count=%0d led0=%b", COUNT, LED[0]);
        tick();
        if ({COUNT, LED[0]} !== {8'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_led_fall: got count=%0d led0=%b, required count=1 led0=0", COUNT, LED[0]);
        end
        vectors++;
        $display("txn wrap_led_fall count=%0d led0=%b", COUNT, LED[0]);
    endtask

    task automatic test_strobe();
        int guard = 0;
        TAP_SEL[5:3] = 3'd2;
        MODE[1] = 1'b1;
        while (COUNT !== 8'd25 && guard < 60) begin
            tick();
            guard++;
            if (LED[1] !== (COUNT[2:0] == 3'd5)) begin
                miscompares++;
                $display("FAIL strobe_tap2 count=%0d: got led1=%b, required %b", COUNT, LED[1], (COUNT[2:0] == 3'd5));
            end
            vectors++;
            $display("txn strobe_tap2 count=%0d led1=%b", COUNT, LED[1]);
        end
        TAP_SEL[5:3] = 3'd3;
        tick();
        if ({COUNT, LED[1]} !== {8'd26, 1'b0}) begin
            miscompares++;
            $display("FAIL strobe_sel_change: got count=%0d led1=%b, required count=26 led1=0", COUNT, LED[1]);
        end
        vectors++;
        $display("txn strobe_sel_change count=%0d led1=%b", COUNT, LED[1]);
        guard = 0;
        while (COUNT !== 8'd41 && guard < 30) begin
            tick();
            guard++;
            if (LED[1] !== (COUNT[3:0] == 4'd9)) begin
                miscompares++;
                $display("FAIL strobe_tap3 count=%0d: got led1=%b, required %b", COUNT, LED[1], (COUNT[3:0] == 4'd9));
            end
            vectors++;
            if ({RUNNING, COUNT, LED} !== {m_run, m_count, m_led}) begin
                miscompares++;
                $display("FAIL strobe_model: got %b/%0d/%b, required %b/%0d/%b",
                         RUNNING, COUNT, LED, m_run, m_count, m_led);
            end
            vectors++;
        end
    endtask

    task automatic test_clear();
        int guard = 0;
        while (COUNT !== 8'd100 && guard < 300) begin
            tick();
            guard++;
        end
        if (COUNT !== 8'd100) begin
            miscompares++;
            $display("FAIL clear_reach: got count=%0d, required 100", COUNT);
        end
        vectors++;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        if ({RUNNING, COUNT} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_edge: got run=%b count=%0d, required run=1 count=0", RUNNING, COUNT);
        end
        vectors++;
        $display("txn clear_edge run=%b count=%0d", RUNNING, COUNT);
        for (int k = 1; k <= 2; k++) begin
            tick();
            if ({RUNNING, COUNT} !== {1'b1, W'(k)}) begin
                miscompares++;
                $display("FAIL clear_resume k=%0d: got run=%b count=%0d, required run=1 count=%0d", k, RUNNING, COUNT, k);
            end
            vectors++;
            $display("txn clear_resume run=%b count=%0d", RUNNING, COUNT);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        #3 BTN_USR = 1'b0;
        #1;
        if ({RUNNING, COUNT, LED} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got run=%b count=%0d led=%b, required all 0", RUNNING, COUNT, LED);
        end
        vectors++;
        $display("txn midrun_reset run=%b count=%0d led=%b", RUNNING, COUNT, LED);
        model_reset();
        repeat (2) @(posedge CLK);
        #1 BTN_USR = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if ({RUNNING, COUNT} !== {(e >= 7) ? 1'b1 : 1'b0, (e >= 7) ? W'(e - 7) : W'(0)}) begin
                miscompares++;
                $display("FAIL reset_requal e=%0d: got run=%b count=%0d, required run=%b count=%0d",
                         e, RUNNING, COUNT, (e >= 7), (e >= 7) ? e - 7 : 0);
            end
            vectors++;
            $display("txn reset_requal e=%0d run=%b count=%0d", e, RUNNING, COUNT);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) PLL_LOCK = ~PLL_LOCK;
            CLR = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) TAP_SEL = CH*TW'($urandom);
            if ($urandom_range(0, 24) == 0) MODE = CH'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                BTN_USR = 1'b0;
                #2 BTN_USR = 1'b1;
                model_reset();
            end
            tick();
            if ({RUNNING, COUNT, LED} !== {m_run, m_count, m_led}) begin
                miscompares++;
                $display("FAIL random n=%0d: got run=%b count=%0d led=%b, required run=%b count=%0d led=%b",
                         n, RUNNING, COUNT, LED, m_run, m_count, m_led);
            end
            vectors++;
            $display("txn random n=%0d lock=%b clr=%b sel=%h mode=%b run=%b count=%0d led=%b",
                     n, PLL_LOCK, CLR, TAP_SEL, MODE, RUNNING, COUNT, LED);
        end
        CLR = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_latency();
        test_qual_dropout();
        test_wrap_level();
        test_strobe();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
